// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// The state encoding doubles as the held-entry count.
package pipe_pkg;

    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 144;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry valid/ready pipeline register: a main register driving the outputs
// and one skid register, so inReady can be registered without losing entries.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clockIn,
    input  logic              reset,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              outValid,
    input  logic              outReady,
    output logic [CTRL_W-1:0] ctrlOut,
    output logic [DATA_W-1:0] dataOut,
    output logic [1:0]        occupancy
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid and its payload hold until that edge.

    stage_state_t      r_state;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    stage_state_t      w_state_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_accept;
    logic              w_consume;

    assign w_accept  = inValid && r_in_ready;
    assign w_consume = (r_state != ST_EMPTY) && outReady;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;
        if (flush) begin
            // A same-cycle consume still takes the head; everything else is dropped.
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = '0;
            w_skid_ctrl_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt     = ST_ONE;
                        w_main_ctrl_nxt = ctrlIn;
                        w_main_data_nxt = dataIn;
                    end
                end
                ST_ONE: begin
                    case ({w_accept, w_consume})
                        2'b10: begin
                            w_state_nxt     = ST_TWO;
                            w_skid_ctrl_nxt = ctrlIn;
                            w_skid_data_nxt = dataIn;
                        end
                        2'b01: begin
                            w_state_nxt     = ST_EMPTY;
                            w_main_ctrl_nxt = '0;
                        end
                        2'b11: begin
                            w_main_ctrl_nxt = ctrlIn;
                            w_main_data_nxt = dataIn;
                        end
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    // inReady is low here, so only a consume can move the state.
                    if (w_consume) begin
                        w_state_nxt     = ST_ONE;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_main_data_nxt = r_skid_data;
                        w_skid_ctrl_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt     = ST_EMPTY;
                    w_main_ctrl_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
        end
    end

    assign inReady   = r_in_ready;
    assign outValid  = (r_state != ST_EMPTY);
    assign ctrlOut   = r_main_ctrl;
    assign dataOut   = r_main_data;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a negedge monitor keeps a FIFO model of accepted
// entries and checks every consumed head, while scenario tasks check the spot values.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 144;
    localparam int ENT_W  = CTRL_W + DATA_W;

    logic              clockIn = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic [CTRL_W-1:0] ctrlIn = '0;
    logic [DATA_W-1:0] dataIn = '0;
    logic              outValid;
    logic              outReady = 1'b0;
    logic [CTRL_W-1:0] ctrlOut;
    logic [DATA_W-1:0] dataOut;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_errors = 0;
    int pop_cnt = 0;
    bit mon_en = 1'b0;
    logic [ENT_W-1:0] exp_q[$];

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clockIn  (clockIn),
        .reset    (reset),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .ctrlIn   (ctrlIn),
        .dataIn   (dataIn),
        .outValid (outValid),
        .outReady (outReady),
        .ctrlOut  (ctrlOut),
        .dataOut  (dataOut),
        .occupancy(occupancy)
    );

    // clock / reset
    always #5 clockIn = ~clockIn;

    // scoreboard monitor
    always @(negedge clockIn) begin
        if (mon_en) begin
            int sz;
            logic [ENT_W-1:0] exp_ent;
            sz = exp_q.size();
            n_checks++;
            if (occupancy !== 2'(sz)) begin
                n_errors++;
                $display("FAIL mon_occupancy got %0d expected %0d", occupancy, sz);
            end
            n_checks++;
            if (outValid !== (sz != 0)) begin
                n_errors++;
                $display("FAIL mon_outValid got %b expected %b", outValid, (sz != 0));
            end
            n_checks++;
            if (inReady !== (sz < 2)) begin
                n_errors++;
                $display("FAIL mon_inReady got %b expected %b", inReady, (sz < 2));
            end
            if (sz == 0) begin
                n_checks++;
                if (ctrlOut !== '0) begin
                    n_errors++;
                    $display("FAIL mon_bubble_ctrl got %h expected 0", ctrlOut);
                end
            end
            if (reset) begin
                exp_q.delete();
            end else begin
                if (outReady && sz > 0) begin
                    exp_ent = exp_q.pop_front();
                    pop_cnt++;
                    n_checks++;
                    if ({ctrlOut, dataOut} !== exp_ent) begin
                        n_errors++;
                        $display("FAIL mon_head got ctrl %h data %h expected ctrl %h data %h",
                                 ctrlOut, dataOut, exp_ent[ENT_W-1:DATA_W], exp_ent[DATA_W-1:0]);
                    end
                end
                if (flush) exp_q.delete();
                else if (inValid && inReady) exp_q.push_back({ctrlIn, dataIn});
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clockIn);
        #1;
    endtask

    task automatic push_entry(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        inValid = 1'b1;
        ctrlIn  = c;
        dataIn  = d;
        step();
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clockIn);
        n_checks++;
        if ({outValid, ctrlOut, dataOut, occupancy, inReady} !== {1'b0, CTRL_W'(0), DATA_W'(0), 2'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_state got v%b c%h d%h o%0d r%b expected v0 c0 d0 o0 r1",
                     outValid, ctrlOut, dataOut, occupancy, inReady);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_single();
        outReady = 1'b1;
        push_entry(16'h0013, DATA_W'(8'hA5));
        @(negedge clockIn);
        n_checks++;
        if ({outValid, ctrlOut, dataOut, occupancy} !== {1'b1, 16'h0013, DATA_W'(8'hA5), 2'd1}) begin
            n_errors++;
            $display("FAIL single_out got v%b c%h d%h o%0d expected v1 c0013 da5 o1",
                     outValid, ctrlOut, dataOut, occupancy);
        end
        step();
        @(negedge clockIn);
        n_checks++;
        if ({outValid, ctrlOut, occupancy} !== {1'b0, CTRL_W'(0), 2'd0}) begin
            n_errors++;
            $display("FAIL single_drain got v%b c%h o%0d expected v0 c0 o0", outValid, ctrlOut, occupancy);
        end
        step();
    endtask

    task automatic test_skid();
        outReady = 1'b0;
        push_entry(16'h0001, DATA_W'(1));
        push_entry(16'h0002, DATA_W'(2));
        for (int i = 0; i < 3; i++) begin
            @(negedge clockIn);
            n_checks++;
            if ({occupancy, inReady, ctrlOut, dataOut} !== {2'd2, 1'b0, 16'h0001, DATA_W'(1)}) begin
                n_errors++;
                $display("FAIL skid_hold got o%0d r%b c%h d%h expected o2 r0 c0001 d1",
                         occupancy, inReady, ctrlOut, dataOut);
            end
            step();
        end
        outReady = 1'b1;
        step();
        @(negedge clockIn);
        n_checks++;
        if ({ctrlOut, occupancy} !== {16'h0002, 2'd1}) begin
            n_errors++;
            $display("FAIL skid_second got c%h o%0d expected c0002 o1", ctrlOut, occupancy);
        end
        step();
        @(negedge clockIn);
        n_checks++;
        if ({outValid, occupancy} !== {1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL skid_empty got v%b o%0d expected v0 o0", outValid, occupancy);
        end
        step();
    endtask

    task automatic test_stream();
        int start_pops;
        int guard;
        bit acc;
        start_pops = pop_cnt;
        guard = 0;
        for (int i = 1; i <= 100; i++) begin
            inValid = 1'b1;
            ctrlIn  = CTRL_W'(i);
            dataIn  = DATA_W'(i * 7 + 3);
            acc = 1'b0;
            while (!acc && guard < 2000) begin
                outReady = 1'($urandom_range(0, 1));
                @(negedge clockIn);
                acc = inReady;
                step();
                guard++;
            end
        end
        inValid = 1'b0;
        outReady = 1'b1;
        while (exp_q.size() != 0 && guard < 2100) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 2000) begin
            n_errors++;
            $display("FAIL stream_timeout got %0d cycles expected under 2000", guard);
        end
        n_checks++;
        if (pop_cnt - start_pops != 100) begin
            n_errors++;
            $display("FAIL stream_count got %0d expected 100", pop_cnt - start_pops);
        end
    endtask

    task automatic test_flush();
        outReady = 1'b0;
        push_entry(16'h0031, DATA_W'(16'h31));
        push_entry(16'h0032, DATA_W'(16'h32));
        flush   = 1'b1;
        inValid = 1'b1;
        ctrlIn  = 16'h0033;
        dataIn  = DATA_W'(16'h33);
        step();
        flush   = 1'b0;
        inValid = 1'b0;
        @(negedge clockIn);
        n_checks++;
        if ({outValid, ctrlOut, occupancy, inReady} !== {1'b0, CTRL_W'(0), 2'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL flush_two got v%b c%h o%0d r%b expected v0 c0 o0 r1",
                     outValid, ctrlOut, occupancy, inReady);
        end
        push_entry(16'h0041, DATA_W'(16'h41));
        flush   = 1'b1;
        inValid = 1'b1;
        ctrlIn  = 16'h0042;
        step();
        flush   = 1'b0;
        inValid = 1'b0;
        @(negedge clockIn);
        n_checks++;
        if ({outValid, occupancy} !== {1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL flush_accept got v%b o%0d expected v0 o0", outValid, occupancy);
        end
        push_entry(16'h0051, DATA_W'(16'h51));
        push_entry(16'h0052, DATA_W'(16'h52));
        outReady = 1'b1;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clockIn);
        n_checks++;
        if ({outValid, occupancy} !== {1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL flush_consume got v%b o%0d expected v0 o0", outValid, occupancy);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset_mid();
        outReady = 1'b0;
        push_entry(16'h0061, DATA_W'(16'h61));
        push_entry(16'h0062, DATA_W'(16'h62));
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clockIn);
        n_checks++;
        if ({outValid, ctrlOut, dataOut, occupancy, inReady} !== {1'b0, CTRL_W'(0), DATA_W'(0), 2'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_mid got v%b c%h d%h o%0d r%b expected v0 c0 d0 o0 r1",
                     outValid, ctrlOut, dataOut, occupancy, inReady);
        end
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_back_to_back();
        outReady = 1'b0;
        push_entry(16'h0100, DATA_W'(16'h100));
        outReady = 1'b1;
        inValid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ctrlIn = CTRL_W'(16'h0101 + i);
            dataIn = DATA_W'(16'h0101 + i);
            step();
            @(negedge clockIn);
            n_checks++;
            if ({occupancy, ctrlOut, inReady} !== {2'd1, CTRL_W'(16'h0101 + i), 1'b1}) begin
                n_errors++;
                $display("FAIL b2b_cycle%0d got o%0d c%h r%b expected o1 c%h r1",
                         i, occupancy, ctrlOut, inReady, CTRL_W'(16'h0101 + i));
            end
        end
        inValid = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_stream();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL final_queue got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
